// File: rtl/jt900h_regs.sv
`default_nettype none
// ============================================================================
//  Module   : jt900h_regs
//  Purpose  : TLCS-900H register file feeding the ALU operand ports.
//             Four banks of XWA/XBC/XDE/XHL, plus XIX/XIY/XIZ/XSP and the
//             2-bit register file pointer RFP. Two combinational read ports
//             (zero-extended byte/word/long) and one write port that takes
//             the ALU result one cycle after the operation issues. Results
//             still pending in the write cycle are forwarded to the reads.
//  Ports    : clk, rst (async, active-high), cen (clock enable)
//             src0/src1 - full 8-bit register codes for op0/op1
//             rd_w      - read width ([0] byte, [1] word, else long)
//             dst       - destination code, issued with the ALU operation
//             alu_we    - write width from the ALU (000 = no write)
//             alu_dout  - ALU result
//             rfp_inc/rfp_dec/rfp_ld/rfp_din - RFP control (ld>inc>dec)
//             op0/op1   - operands, rfp - current bank pointer
//  Revision : 1.0 - initial release
// ============================================================================
module jt900h_regs #(
    parameter logic [31:0] XSP_RST   = 32'h0000_0100,
    parameter bit          PREV_WRAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [7:0]  src0,
    input  logic [7:0]  src1,
    input  logic [2:0]  rd_w,
    input  logic [7:0]  dst,
    input  logic [2:0]  alu_we,
    input  logic [31:0] alu_dout,
    input  logic        rfp_inc,
    input  logic        rfp_dec,
    input  logic        rfp_ld,
    input  logic [1:0]  rfp_din,
    output logic [31:0] op0,
    output logic [31:0] op1,
    output logic [1:0]  rfp
);

    // Physical storage: entries 0..15 are bank*4+reg, 16..19 are XIX..XSP.
    localparam int         c_NUM_REGS = 20;
    localparam logic [4:0] c_XSP_IDX  = 5'd19;

    logic [31:0] r_regs [0:c_NUM_REGS-1];
    logic [1:0]  r_rfp;
    logic [7:0]  r_dst_l;

    // Resolves a register code to {valid, physical index}.
    function automatic logic [5:0] f_decode(input logic [7:0] code,
                                            input logic [1:0] bank_ptr);
        logic [1:0] prev;
        logic [5:0] res;
        prev = bank_ptr - 2'd1;
        if (!PREV_WRAP && bank_ptr == 2'd0)
            prev = 2'd0;
        res = 6'd0;
        if (code[7:6] == 2'b00)
            res = {2'b10, code[5:4], code[3:2]};
        else if (code[7:4] == 4'hD)
            res = {2'b10, prev, code[3:2]};
        else if (code[7:4] == 4'hE)
            res = {2'b10, bank_ptr, code[3:2]};
        else if (code[7:4] == 4'hF)
            res = {4'b1100, code[3:2]};
        return res;
    endfunction

    // Merges a write of the given width into the old register contents.
    function automatic logic [31:0] f_merge(input logic [31:0] old,
                                            input logic [2:0]  width,
                                            input logic [1:0]  lane,
                                            input logic [31:0] din);
        logic [31:0] v;
        v = old;
        if (width[0])
            v[{lane, 3'b000} +: 8] = din[7:0];
        else if (width[1])
            v[{lane[1], 4'b0000} +: 16] = din[15:0];
        else
            v = din;
        return v;
    endfunction

    // Picks the requested lane(s) and zero-extends.
    function automatic logic [31:0] f_extract(input logic [31:0] v,
                                              input logic [2:0]  width,
                                              input logic [1:0]  lane);
        logic [31:0] res;
        if (width[0])
            res = {24'd0, v[{lane, 3'b000} +: 8]};
        else if (width[1])
            res = {16'd0, v[{lane[1], 4'b0000} +: 16]};
        else
            res = v;
        return res;
    endfunction

    logic [5:0]  w_wr_dec;
    logic        w_wr_pend;
    logic [31:0] w_wr_val;
    logic [5:0]  w_rd0_dec;
    logic [5:0]  w_rd1_dec;
    logic [31:0] w_rd0_raw;
    logic [31:0] w_rd1_raw;

    // The write resolves against the RFP in effect before this edge, so a
    // simultaneous RFP update never redirects the data.
    assign w_wr_dec  = f_decode(r_dst_l, r_rfp);
    assign w_wr_pend = (alu_we != 3'd0) && w_wr_dec[5];
    assign w_wr_val  = f_merge(r_regs[w_wr_dec[4:0]], alu_we, r_dst_l[1:0], alu_dout);

    assign w_rd0_dec = f_decode(src0, r_rfp);
    assign w_rd1_dec = f_decode(src1, r_rfp);

    // Forwarding: the merged value already carries unwritten lanes from
    // storage, so a whole-register substitution is sufficient.
    assign w_rd0_raw = (w_wr_pend && w_rd0_dec[4:0] == w_wr_dec[4:0]) ?
                       w_wr_val : r_regs[w_rd0_dec[4:0]];
    assign w_rd1_raw = (w_wr_pend && w_rd1_dec[4:0] == w_wr_dec[4:0]) ?
                       w_wr_val : r_regs[w_rd1_dec[4:0]];

    assign op0 = w_rd0_dec[5] ? f_extract(w_rd0_raw, rd_w, src0[1:0]) : 32'd0;
    assign op1 = w_rd1_dec[5] ? f_extract(w_rd1_raw, rd_w, src1[1:0]) : 32'd0;
    assign rfp = r_rfp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_NUM_REGS; i++)
                r_regs[i] <= 32'd0;
            r_regs[c_XSP_IDX] <= XSP_RST;
            r_rfp   <= 2'd0;
            r_dst_l <= 8'd0;
        end else if (cen) begin
            if (w_wr_pend)
                r_regs[w_wr_dec[4:0]] <= w_wr_val;
            r_dst_l <= dst;
            if (rfp_ld)
                r_rfp <= rfp_din;
            else if (rfp_inc)
                r_rfp <= r_rfp + 2'd1;
            else if (rfp_dec)
                r_rfp <= r_rfp - 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jt900h_regs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jt900h_regs
//  Purpose  : Self-checking bench for jt900h_regs. Directed steps followed by
//             random traffic, compared against a register-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jt900h_regs;

    localparam bit          PREV_WRAP = 1'b1;
    localparam logic [31:0] XSP_RST   = 32'h0000_0100;
    localparam logic [2:0]  BYTE = 3'b001, WORD = 3'b010, LONG = 3'b100;

    logic        clk = 1'b0;
    logic        rst, cen;
    logic [7:0]  src0, src1, dst;
    logic [2:0]  rd_w, alu_we;
    logic [31:0] alu_dout;
    logic        rfp_inc, rfp_dec, rfp_ld;
    logic [1:0]  rfp_din;
    logic [31:0] op0, op1;
    logic [1:0]  rfp;

    int total = 0;
    int bad   = 0;

    jt900h_regs #(.XSP_RST(XSP_RST), .PREV_WRAP(PREV_WRAP)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .src0(src0), .src1(src1), .rd_w(rd_w),
        .dst(dst), .alu_we(alu_we), .alu_dout(alu_dout),
        .rfp_inc(rfp_inc), .rfp_dec(rfp_dec), .rfp_ld(rfp_ld), .rfp_din(rfp_din),
        .op0(op0), .op1(op1), .rfp(rfp)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] bank_m [4][4];
    logic [31:0] ded_m  [4];
    int          rfp_m;
    logic [7:0]  dstl_m;

    task automatic model_reset();
        for (int b = 0; b < 4; b++)
            for (int r = 0; r < 4; r++)
                bank_m[b][r] = 32'd0;
        for (int r = 0; r < 3; r++)
            ded_m[r] = 32'd0;
        ded_m[3] = XSP_RST;
        rfp_m  = 0;
        dstl_m = 8'd0;
    endtask

    // Register identity: -1 invalid, 0..15 bank*4+reg, 16..19 dedicated.
    function automatic int phys(input logic [7:0] code, input int bp);
        int c;
        int b;
        c = int'(code);
        if (c < 64)
            return (c / 16) * 4 + (c % 16) / 4;
        if (c >= 208 && c < 224) begin
            if (bp == 0)
                b = PREV_WRAP ? 3 : 0;
            else
                b = bp - 1;
            return b * 4 + (c % 16) / 4;
        end
        if (c >= 224 && c < 240)
            return bp * 4 + (c % 16) / 4;
        if (c >= 240)
            return 16 + (c % 16) / 4;
        return -1;
    endfunction

    function automatic logic [31:0] stored(input int id);
        if (id < 16)
            return bank_m[id / 4][id % 4];
        return ded_m[id - 16];
    endfunction

    function automatic logic [31:0] apply(input logic [31:0] v, input logic [2:0] we,
                                          input logic [7:0] code, input logic [31:0] d);
        int lane;
        int half;
        lane = int'(code) % 4;
        half = (int'(code) / 2) % 2;
        if (we[0])
            return (v & ~(32'hFF << (8 * lane))) | ((d & 32'hFF) << (8 * lane));
        if (we[1])
            return (v & ~(32'hFFFF << (16 * half))) | ((d & 32'hFFFF) << (16 * half));
        return d;
    endfunction

    function automatic logic [31:0] expect_op(input logic [7:0] code, input logic [2:0] w);
        int id;
        logic [31:0] v;
        id = phys(code, rfp_m);
        if (id < 0)
            return 32'd0;
        v = stored(id);
        if (alu_we != 3'd0 && phys(dstl_m, rfp_m) == id)
            v = apply(v, alu_we, dstl_m, alu_dout);
        if (w[0])
            return (v >> (8 * (int'(code) % 4))) & 32'hFF;
        if (w[1])
            return (v >> (16 * ((int'(code) / 2) % 2))) & 32'hFFFF;
        return v;
    endfunction

    task automatic commit();
        int id;
        if (cen) begin
            if (alu_we != 3'd0) begin
                id = phys(dstl_m, rfp_m);
                if (id >= 0 && id < 16)
                    bank_m[id / 4][id % 4] = apply(stored(id), alu_we, dstl_m, alu_dout);
                else if (id >= 16)
                    ded_m[id - 16] = apply(stored(id), alu_we, dstl_m, alu_dout);
            end
            dstl_m = dst;
            if (rfp_ld)
                rfp_m = int'(rfp_din);
            else if (rfp_inc)
                rfp_m = (rfp_m + 1) % 4;
            else if (rfp_dec)
                rfp_m = (rfp_m + 3) % 4;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] s0, input logic [7:0] s1, input logic [2:0] w,
                         input logic [7:0] d, input logic [2:0] we, input logic [31:0] dout,
                         input logic inc, input logic dec, input logic ld,
                         input logic [1:0] din, input logic ce);
        src0 = s0; src1 = s1; rd_w = w; dst = d; alu_we = we; alu_dout = dout;
        rfp_inc = inc; rfp_dec = dec; rfp_ld = ld; rfp_din = din; cen = ce;
    endtask

    task automatic check_now();
        chk("op0", op0, expect_op(src0, rd_w));
        chk("op1", op1, expect_op(src1, rd_w));
        chk("rfp", {30'd0, rfp}, 32'(rfp_m));
    endtask

    task automatic check_cycle();
        #4;
        check_now();
    endtask

    task automatic tick();
        commit();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rand_code();
        logic [7:0] r;
        r = 8'($urandom_range(0, 15));
        case ($urandom_range(0, 4))
            0: return 8'($urandom_range(0, 63));
            1: return 8'hD0 | r;
            2: return 8'hE0 | r;
            3: return 8'hF0 | r;
            default: return 8'($urandom);
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        drive(8'h00, 8'h00, LONG, 8'h00, 3'd0, 32'd0, 0, 0, 0, 2'd0, 1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset contents
        drive(8'hFC, 8'hE0, LONG, 8'h00, 3'd0, 32'd0, 0, 0, 0, 2'd0, 1);
        check_cycle();
        chk("rst_xsp", op0, 32'h0000_0100);
        chk("rst_e0", op1, 32'd0);
        tick();

        // Issue dst=E0, then long write with same-cycle forwarding
        drive(8'hE0, 8'hE0, LONG, 8'hE0, 3'd0, 32'd0, 0, 0, 0, 2'd0, 1);
        check_cycle(); tick();
        drive(8'hE1, 8'hFC, BYTE, 8'hE3, LONG, 32'hDEAD_BEEF, 0, 0, 0, 2'd0, 1);
        check_cycle();
        chk("fwd_byte", op0, 32'h0000_00BE);
        tick();
        drive(8'hE2, 8'hE0, WORD, 8'hE3, 3'd0, 32'd0, 0, 0, 0, 2'd0, 1);
        check_cycle();
        chk("word_hi", op0, 32'h0000_DEAD);
        tick();

        // Partial writes preserve the other lanes
        drive(8'hE0, 8'hE3, LONG, 8'hE1, BYTE, 32'h0000_005A, 0, 0, 0, 2'd0, 1);
        check_cycle();
        chk("byte_merge", op0, 32'h5AAD_BEEF);
        tick();
        drive(8'hE0, 8'hE1, LONG, 8'h00, WORD, 32'h0000_1234, 0, 0, 0, 2'd0, 1);
        check_cycle();
        chk("word_merge", op0, 32'h5AAD_1234);
        tick();

        // DECF wraps 0 -> 3; write lands in bank 3
        drive(8'hE0, 8'hE1, WORD, 8'h00, 3'd0, 32'd0, 0, 1, 0, 2'd0, 1);
        check_cycle();
        chk("word_lo", op1, 32'h0000_1234);
        tick();
        drive(8'h34, 8'hE4, LONG, 8'hE4, 3'd0, 32'd0, 0, 0, 0, 2'd0, 1);
        check_cycle();
        chk("dec_wrap", {30'd0, rfp}, 32'd3);
        tick();
        drive(8'h34, 8'h04, LONG, 8'h00, LONG, 32'h1122_3344, 1, 0, 0, 2'd0, 1);
        check_cycle();
        chk("bank3_fwd", op0, 32'h1122_3344);
        tick();
        drive(8'hD4, 8'h34, LONG, 8'hE8, 3'd0, 32'd0, 0, 0, 0, 2'd0, 1);
        check_cycle();
        chk("inc_wrap", {30'd0, rfp}, 32'd0);
        chk("prev_bank", op0, 32'h1122_3344);
        tick();

        // LDF beats INCF; write bank uses the pre-update RFP
        drive(8'h08, 8'hE8, LONG, 8'h80, LONG, 32'hCAFE_F00D, 1, 0, 1, 2'd2, 1);
        check_cycle(); tick();
        drive(8'h08, 8'hE8, LONG, 8'h80, 3'd0, 32'd0, 0, 0, 0, 2'd0, 1);
        check_cycle();
        chk("ld_wins", {30'd0, rfp}, 32'd2);
        chk("old_bank", op0, 32'hCAFE_F00D);
        chk("new_bank", op1, 32'd0);
        tick();

        // Invalid destination is dropped
        drive(8'h80, 8'h00, LONG, 8'hE0, LONG, 32'hFFFF_FFFF, 0, 0, 0, 2'd0, 1);
        check_cycle();
        chk("inv_read", op0, 32'd0);
        tick();
        drive(8'h80, 8'h08, LONG, 8'hE0, 3'd0, 32'd0, 0, 0, 0, 2'd0, 1);
        check_cycle();
        chk("inv_drop", op1, 32'hCAFE_F00D);
        tick();

        // cen low freezes RFP and dst_l
        drive(8'hE8, 8'h08, LONG, 8'hE0, 3'd0, 32'd0, 1, 0, 0, 2'd0, 0);
        check_cycle(); tick();
        drive(8'hE8, 8'h08, LONG, 8'hE0, 3'd0, 32'd0, 0, 0, 0, 2'd0, 1);
        check_cycle();
        chk("cen_hold", {30'd0, rfp}, 32'd2);
        tick();

        // Asynchronous reset in the middle of a write cycle
        drive(8'hE0, 8'hFC, LONG, 8'h00, LONG, 32'h1234_5678, 0, 0, 0, 2'd0, 1);
        #2;
        rst = 1'b1;
        alu_we = 3'd0;
        model_reset();
        #2;
        check_now();
        chk("rst_mid_e0", op0, 32'd0);
        chk("rst_mid_xsp", op1, 32'h0000_0100);
        chk("rst_mid_rfp", {30'd0, rfp}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(8'hE0, 8'h20, LONG, 8'h00, 3'd0, 32'd0, 0, 0, 0, 2'd0, 1);
        check_cycle();
        chk("rst_discard", op0, 32'd0);
        tick();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            drive(rand_code(), rand_code(), 3'($urandom_range(0, 7)), rand_code(),
                  3'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 4) != 0));
            check_cycle();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
